// File: rtl/modexp_arbiter.sv
// rtl/modexp_arbiter.sv - round-robin arbiter sharing one modexp engine between two requesters
module modexp_arbiter #(
    parameter int          WIDTH   = 4096,
    parameter logic [31:0] TIMEOUT = 32'd100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_message,
    input  logic [WIDTH-1:0] req0_exponent,
    input  logic [WIDTH-1:0] req0_modulus,
    input  logic [WIDTH-1:0] req1_message,
    input  logic [WIDTH-1:0] req1_exponent,
    input  logic [WIDTH-1:0] req1_modulus,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             eng_go,
    output logic [WIDTH-1:0] eng_message,
    output logic [WIDTH-1:0] eng_exponent,
    output logic [WIDTH-1:0] eng_modulus,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_cypher,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RELEASE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_served;
    logic [31:0] count;
    logic [31:0] count_inc;
    logic        timed_out;
    logic        pick;
    logic        take;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last_served;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    // Gated by rst_n so no handshake can complete while reset is held.
    assign take       = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = take && !pick;
    assign req1_ready = take && pick;

    assign count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    assign timed_out = (count_inc >= TIMEOUT);

    always_comb begin
        state_nx   = state;
        eng_go     = 1'b0;
        busy       = 1'b1;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (take) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                eng_go   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                eng_go = 1'b1;
                if (eng_done || timed_out) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (!eng_done) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_served  <= 1'b1;
            count        <= 32'd0;
            grant_id     <= 1'b0;
            eng_message  <= '0;
            eng_exponent <= '0;
            eng_modulus  <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (take) begin
                        grant_id     <= pick;
                        eng_message  <= pick ? req1_message  : req0_message;
                        eng_exponent <= pick ? req1_exponent : req0_exponent;
                        eng_modulus  <= pick ? req1_modulus  : req0_modulus;
                    end
                end
                ISSUE: begin
                    count <= 32'd0;
                end
                WAIT: begin
                    count <= count_inc;
                    // A completion on the timeout cycle still counts as success.
                    if (eng_done) begin
                        rsp_data <= eng_cypher;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    last_served <= grant_id;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
